// File: rtl/src_read.sv
// Wishbone burst-free source reader: fetches len 64-bit words from src_addr into a source FIFO.
// Optional SRC_READ_TIMEOUT_EN adds a 255-cycle per-beat ack timeout that ends in ERR.
module src_read (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [7:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [63:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        fifo_putn,
    output logic [63:0] fifo_data,
    output logic        fifo_last,
    input  logic        fifo_full,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic [31:0] adr_q, adr_nx;
    logic [15:0] rem_q, rem_nx;
    logic        in_beat_q, in_beat_nx;
    logic        stb;

`ifdef SRC_READ_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_nx;
`endif

    // Handshake: a beat is launched when stb rises; stb, cyc and address are then
    // frozen (in_beat_q) until the slave answers with ack or err, regardless of fifo_full.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            adr_q     <= 32'h0;
            rem_q     <= 16'h0;
            in_beat_q <= 1'b0;
        end else begin
            state     <= state_nx;
            adr_q     <= adr_nx;
            rem_q     <= rem_nx;
            in_beat_q <= in_beat_nx;
        end
    end

`ifdef SRC_READ_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) to_cnt_q <= 8'h0;
        else          to_cnt_q <= to_cnt_nx;
    end

    always_comb begin
        to_cnt_nx = 8'h0;
        if (stb && !wbm_ack_i && !wbm_err_i) to_cnt_nx = to_cnt_q + 8'd1;
    end
`endif

    always_comb begin
        state_nx   = state;
        adr_nx     = adr_q;
        rem_nx     = rem_q;
        in_beat_nx = 1'b0;
        stb        = 1'b0;
        fifo_putn  = 1'b1;
        fifo_last  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (len != 16'h0) begin
                        adr_nx   = {src_addr[31:3], 3'b000};
                        rem_nx   = len;
                        state_nx = REQ;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            REQ: begin
                stb = in_beat_q || !fifo_full;
                if (stb) begin
                    if (wbm_err_i) begin
                        state_nx = ERR;
                    end else if (wbm_ack_i) begin
                        fifo_putn = 1'b0;
                        fifo_last = (rem_q == 16'd1);
                        adr_nx    = adr_q + 32'd8;
                        rem_nx    = rem_q - 16'd1;
                        state_nx  = (rem_q == 16'd1) ? DONE : GAP;
                    end else begin
                        in_beat_nx = 1'b1;
`ifdef SRC_READ_TIMEOUT_EN
                        if (to_cnt_q == 8'd255) begin
                            in_beat_nx = 1'b0;
                            state_nx   = ERR;
                        end
`endif
                    end
                end
            end
            GAP:     state_nx = REQ;
            default: state_nx = IDLE;
        endcase
    end

    assign wbm_cyc_o = stb;
    assign wbm_stb_o = stb;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 8'hFF;
    assign wbm_adr_o = adr_q;
    assign fifo_data = wbm_dat_i;
    assign busy      = (state == REQ) || (state == GAP);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign dbg_state = state;

endmodule

// File: tb/tb_src_read.sv
// Bench for src_read: random wait states and FIFO back-pressure against an address/data
// reference model with an expected-word queue, plus directed corner cases.
module tb_src_read;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [31:0] src_addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [7:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic        fifo_putn, fifo_last, fifo_full;
    logic [63:0] fifo_data;
    logic [2:0]  dbg_state;

    int pass_cnt = 0;
    int fail_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] seed;

    src_read dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .src_addr(src_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .fifo_putn(fifo_putn), .fifo_data(fifo_data), .fifo_last(fifo_last), .fifo_full(fifo_full),
        .dbg_state(dbg_state)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a, a ^ seed};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer driven cycle by cycle; err_beat < 0 means no bus error.
    task automatic xfer(input logic [31:0] a, input logic [15:0] n, input int full_pct,
                        input int full_first, input int max_wait, input int err_beat);
        logic [31:0] cur_addr;
        int          beat, waitc, nwords;
        bit          pending, gap, finished, got_err, write;
        cur_addr = {a[31:3], 3'b000};
        nwords   = (err_beat >= 0) ? err_beat : int'(n);
        for (int i = 0; i < nwords; i++) exp_q.push_back(mem(cur_addr + 32'(i * 8)));
        @(negedge wb_clk_i);
        start = 1'b1; src_addr = a; len = n; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; fifo_full = 1'b0;
        @(negedge wb_clk_i);
        start = 1'b0; src_addr = $urandom; len = 16'($urandom);
        if (n == 16'h0) begin
            #1;
            chk("len0_done", done, 1'b1);
            chk("len0_cyc", wbm_cyc_o, 1'b0);
            chk("len0_putn", fifo_putn, 1'b1);
            return;
        end
        beat = 0; pending = 0; gap = 0; finished = 0; got_err = 0;
        waitc = $urandom_range(0, max_wait);
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            fifo_full = (cyc < full_first) || ($urandom_range(0, 99) < full_pct);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = {$urandom, $urandom};
            #1;
            if (cyc == 0) begin
                chk("start_clr_err", err, 1'b0);
                chk("start_clr_done", done, 1'b0);
            end
            chk("busy", busy, 1'b1);
            if (pending) begin
                chk("stb_hold", wbm_stb_o, 1'b1);
                chk("adr_hold", wbm_adr_o, cur_addr);
            end else if (gap || fifo_full) begin
                chk("stb_low", wbm_stb_o, 1'b0);
            end else begin
                chk("stb_req", wbm_stb_o, 1'b1);
            end
            gap = 0;
            if (wbm_stb_o) begin
                if (!pending) chk("adr", wbm_adr_o, cur_addr);
                pending = 1;
                if (waitc == 0) begin
                    if (beat == err_beat) begin
                        wbm_err_i = 1'b1;
                        wbm_ack_i = 1'($urandom_range(0, 1));
                    end else begin
                        wbm_ack_i = 1'b1;
                    end
                    wbm_dat_i = mem(cur_addr);
                end else begin
                    waitc--;
                end
            end
            #1;
            write = wbm_ack_i && !wbm_err_i;
            chk("putn", fifo_putn, !write);
            if (write) begin
                if (exp_q.size() == 0) chk("extra_write", 1'b1, 1'b0);
                else chk("fifo_data", fifo_data, exp_q.pop_front());
                chk("fifo_last", fifo_last, (beat == int'(n) - 1));
            end else begin
                chk("last_idle", fifo_last, 1'b0);
            end
            if (wbm_err_i) begin
                finished = 1; got_err = 1;
            end else if (wbm_ack_i) begin
                pending = 0; beat++; cur_addr = cur_addr + 32'd8;
                waitc = $urandom_range(0, max_wait);
                if (beat == int'(n)) finished = 1;
                else gap = 1;
            end
            @(negedge wb_clk_i);
        end
        chk("xfer_bound", finished, 1'b1);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; fifo_full = 1'b0;
        #1;
        chk("end_done", done, !got_err);
        chk("end_err", err, got_err);
        chk("end_cyc", wbm_cyc_o, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int first_low;
        seed = $urandom;
        wb_rst_i = 1'b1; start = 1'b0; src_addr = 32'h0; len = 16'h0;
        wbm_dat_i = 64'h0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; fifo_full = 1'b0;
        #1;
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_putn", fifo_putn, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("const_we", wbm_we_o, 1'b0);
        chk("const_sel", wbm_sel_o, 8'hFF);
        @(negedge wb_clk_i); @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        xfer(32'h0000_1005, 16'd3, 0, 0, 0, -1);      // zero-wait example
        xfer(32'h0000_2000, 16'd0, 0, 0, 0, -1);      // empty transfer
        xfer(32'h0000_3000, 16'd5, 0, 10, 0, -1);     // FIFO full first 10 cycles
        xfer(32'h0000_4000, 16'd4, 0, 0, 2, 1);       // bus error on beat 2
        xfer(32'h0000_4800, 16'd2, 0, 0, 1, -1);      // clears err
        xfer(32'hFFFF_FFF8, 16'd2, 0, 0, 0, -1);      // address wrap
        for (int t = 0; t < 6; t++)
            xfer($urandom, 16'($urandom_range(1, 12)), 30, 0, 3, -1);
        xfer($urandom, 16'd6, 40, 0, 4, $urandom_range(0, 5));

        // Withheld ack: timeout variant ends the beat after 256 stb cycles.
        @(negedge wb_clk_i);
        start = 1'b1; src_addr = 32'h0000_8000; len = 16'd1;
        @(negedge wb_clk_i);
        start = 1'b0;
        first_low = -1;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (!wbm_stb_o && first_low < 0) first_low = i;
            @(negedge wb_clk_i);
        end
`ifdef SRC_READ_TIMEOUT_EN
        chk("timeout_cycle", first_low, 256);
        chk("timeout_err", err, 1'b1);
`else
        chk("no_timeout", first_low, -1);
`endif
        wb_rst_i = 1'b1;
        #1;
        chk("midrst_cyc", wbm_cyc_o, 1'b0);
        chk("midrst_putn", fifo_putn, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_adr", wbm_adr_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        xfer(32'h0000_9003, 16'd3, 20, 0, 2, -1);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/src_read.md
SRC_READ -- requirements
Module: src_read

Interface
REQ-001 SHALL have ports: wb_clk_i input 1 clock; wb_rst_i input 1 asynchronous active-high reset.
REQ-002 SHALL have: start input 1, one-cycle pulse launching a transfer; src_addr input 32, byte start address; len input 16, transfer length in 64-bit words.
REQ-003 SHALL have: busy output 1; done output 1; err output 1.
REQ-004 SHALL have Wishbone master: wbm_cyc_o out 1; wbm_stb_o out 1; wbm_we_o out 1 (constant 0); wbm_sel_o out 8 (constant 8'hFF); wbm_adr_o out 32; wbm_dat_i in 64; wbm_ack_i in 1; wbm_err_i in 1.
REQ-005 SHALL have source-FIFO write side: fifo_putn out 1, active-low write strobe; fifo_data out 64; fifo_last out 1, marks final word; fifo_full in 1.

Function
REQ-006 SHALL implement states IDLE, REQ, GAP, DONE, ERR; IDLE after reset.
REQ-007 IDLE: on start with len!=0, SHALL latch src_addr with bits [2:0] forced 0, latch len into a 16-bit remaining counter, and enter REQ.
REQ-008 IDLE: on start with len==0, SHALL enter DONE with no bus cycle and no FIFO write.
REQ-009 REQ: SHALL assert wbm_cyc_o and wbm_stb_o only while fifo_full==0; with fifo_full==1, cyc/stb SHALL be low and REQ held.
REQ-010 Once stb is asserted, stb, cyc and wbm_adr_o SHALL stay stable until ack or err, even if fifo_full rises.
REQ-011 On wbm_ack_i with stb high: fifo_putn SHALL be low in that same cycle; fifo_data SHALL equal wbm_dat_i; fifo_last SHALL be 1 iff remaining==1.
REQ-012 Same ack edge: address SHALL advance by 8 (modulo 2^32 wrap); remaining SHALL decrement; next state SHALL be DONE if remaining was 1, else GAP.
REQ-013 GAP: SHALL hold cyc/stb low for exactly one cycle, then enter REQ; peak throughput is one word per 2 cycles.
REQ-014 On wbm_err_i with stb high: SHALL perform no FIFO write, drop cyc/stb, and enter ERR.
REQ-015 ack and err in the same cycle SHALL be treated as err.
REQ-016 DONE: done SHALL be 1. ERR: err SHALL be 1. Both SHALL hold until the next accepted start, which SHALL clear them and apply REQ-007/008.
REQ-017 busy SHALL be 1 in REQ and GAP; start SHALL be ignored while busy.
REQ-018 fifo_putn SHALL be 1 in every cycle other than the REQ-011 cycle; fifo_last SHALL be 0 whenever fifo_putn is 1.

Reset
REQ-019 wb_rst_i high SHALL immediately force: state IDLE; cyc, stb, busy, done, err = 0; fifo_putn = 1; fifo_last = 0; wbm_adr_o, remaining = 0.
REQ-020 Reset mid-transfer SHALL abandon the transfer with no further FIFO write; the next start after release SHALL behave as from power-up.

Configuration
REQ-021 Macro SRC_READ_TIMEOUT_EN, when defined, SHALL add an 8-bit counter that clears on each stb rising and increments each cycle stb is high without ack/err.
REQ-022 With SRC_READ_TIMEOUT_EN, when the count reaches 255 and ack/err are still absent, the block SHALL drop cyc/stb and enter ERR.
REQ-023 Without SRC_READ_TIMEOUT_EN, the block SHALL wait for ack/err indefinitely and SHALL contain no counter logic.

Verification
REQ-024 start, src_addr=32'h1005, len=3, zero-wait ack -> reads at 1000, 1008, 1010; 3 putn pulses; fifo_last only on word 3; done=1.
REQ-025 len=0 -> no cyc; done=1 the cycle after start; fifo_putn stays 1.
REQ-026 fifo_full=1 for 10 cycles during REQ -> stb low throughout; transfer resumes and completes with correct data order.
REQ-027 err on beat 2 of len=4 -> exactly 1 FIFO write; err=1; cyc low; a subsequent start clears err.
REQ-028 src_addr=32'hFFFFFFF8, len=2 -> second read at 32'h00000000.
REQ-029 With SRC_READ_TIMEOUT_EN, ack withheld -> ERR entered at 255 count; without the macro -> stb remains high after 1000 cycles; reset asserted mid-beat -> cyc low immediately.
